// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared types and constants for the fetch buffer.
// Defines the dispatch packet, buffer entry and line geometry.
package fetch_buffer_pkg;

  localparam int XLEN = 32;
  localparam int FB_LINE_INSTS = 2;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
  } prefetch_packet_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fb_entry_t;

endpackage

// File: rtl/fetch_line_split.sv
// fetch_line_split: splits a 64-bit line into 0..2 buffer entries.
// Ports: fetch_pc, Imem2proc_data, fire in; enq_num, ent0, ent1 out.
module fetch_line_split
  import fetch_buffer_pkg::*;
(
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [63:0]     Imem2proc_data,
  input  logic            fire,
  output logic [1:0]      enq_num,
  output fb_entry_t       ent0,
  output fb_entry_t       ent1
);

  logic [XLEN-1:0] aligned;

  assign aligned = {fetch_pc[XLEN-1:3], 3'b0};

  always_comb begin
    enq_num = '0;
    ent0    = '0;
    ent1    = '0;
    unique case (1'b1)
      fire && !fetch_pc[2]: begin
        enq_num   = 2'd2;
        ent0.inst = Imem2proc_data[31:0];
        ent0.pc   = aligned;
        ent1.inst = Imem2proc_data[63:32];
        ent1.pc   = aligned + XLEN'(4);
      end
      fire && fetch_pc[2]: begin
        enq_num   = 2'd1;
        ent0.inst = Imem2proc_data[63:32];
        ent0.pc   = fetch_pc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction buffer between imem and dispatch.
// Ports: clock, reset, flush/flush_pc, imem req/addr/valid/data,
// dispatch_cnt in, packet_out and count out.
// Macro FETCH_BUF_BYPASS_EN: present incoming line when buffer is empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int OUT_WIDTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [XLEN-1:0]                flush_pc,
  input  logic                           Imem2proc_valid,
  input  logic [63:0]                    Imem2proc_data,
  output logic                           proc2Imem_req,
  output logic [XLEN-1:0]                proc2Imem_addr,
  input  logic [$clog2(OUT_WIDTH+1)-1:0] dispatch_cnt,
  output prefetch_packet_t [OUT_WIDTH-1:0] packet_out,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  fb_entry_t       mem [DEPTH];

  logic            fire;
  logic [1:0]      enq_num;
  fb_entry_t       ent0;
  fb_entry_t       ent1;
  logic [CW-1:0]   avail;
  logic [CW-1:0]   deq;

  // Only registered count feeds the request, never dispatch_cnt.
  assign proc2Imem_req  = !reset && (count <= CW'(DEPTH-2));
  assign proc2Imem_addr = reset ? '0 : {fetch_pc[XLEN-1:3], 3'b0};
  assign fire = proc2Imem_req && Imem2proc_valid && !flush;

  fetch_line_split u_split (
    .fetch_pc       (fetch_pc),
    .Imem2proc_data (Imem2proc_data),
    .fire           (fire),
    .enq_num        (enq_num),
    .ent0           (ent0),
    .ent1           (ent1)
  );

  // Number of slots presented as valid this cycle.
  always_comb begin
    avail = '0;
    if (!reset && !flush) begin
      if (count >= CW'(OUT_WIDTH))
        avail = CW'(OUT_WIDTH);
      else
        avail = count;
`ifdef FETCH_BUF_BYPASS_EN
      if (count == '0 && fire)
        avail = (CW'(enq_num) > CW'(OUT_WIDTH))
              ? CW'(OUT_WIDTH) : CW'(enq_num);
`endif
    end
  end

  // Over-dispatch is clamped to what was actually presented.
  assign deq = (CW'(dispatch_cnt) > avail) ? avail : CW'(dispatch_cnt);

  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_slot
    logic [PW-1:0]    idx;
    fb_entry_t        src;
    prefetch_packet_t pkt;

    assign idx = head + PW'(i);
`ifdef FETCH_BUF_BYPASS_EN
    // With an empty buffer head==tail, so the line goes straight out.
    assign src = (count == '0) ? ((i == 0) ? ent0 : ent1) : mem[idx];
`else
    assign src = mem[idx];
`endif
    assign pkt.valid = 1'b1;
    assign pkt.inst  = src.inst;
    assign pkt.pc    = src.pc;
    assign pkt.npc   = src.pc + XLEN'(4);
    assign packet_out[i] = (CW'(i) < avail) ? pkt : '0;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= reset ? '0 : flush_pc;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(enq_num);
      count <= count - deq + CW'(enq_num);
      if (fire)
        fetch_pc <= {fetch_pc[XLEN-1:3], 3'b0} + XLEN'(8);
    end
  end

  // Bypassed entries are still written; head skips the consumed ones.
  always_ff @(posedge clock) begin
    if (enq_num != 2'd0)
      mem[tail] <= ent0;
    if (enq_num == 2'd2)
      mem[tail + PW'(1)] <= ent1;
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush)
      assert (CW'(dispatch_cnt) <= avail)
        else $warning("fetch_buffer: dispatch_cnt exceeds valid slots");
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer.
// Memory returns inst = 0xC0DE0000 | pc for every address.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

`ifdef FETCH_BUF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [31:0]            flush_pc;
  logic                   mem_valid;
  logic [63:0]            mem_data;
  logic                   req;
  logic [31:0]            addr;
  logic [1:0]             dcnt;
  prefetch_packet_t [1:0] pkt;
  logic [3:0]             count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  assign mem_data = {TAG | (addr + 32'd4), TAG | addr};

  fetch_buffer #(.DEPTH(8), .OUT_WIDTH(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .Imem2proc_valid (mem_valid),
    .Imem2proc_data  (mem_data),
    .proc2Imem_req   (req),
    .proc2Imem_addr  (addr),
    .dispatch_cnt    (dcnt),
    .packet_out      (pkt),
    .count           (count)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input int s,
                         input logic v, input logic [31:0] pc);
    if (v) begin
      check($sformatf("%s s%0d valid", tag, s), 128'(pkt[s].valid), 1);
      check($sformatf("%s s%0d pc", tag, s), 128'(pkt[s].pc), 128'(pc));
      check($sformatf("%s s%0d npc", tag, s), 128'(pkt[s].npc),
            128'(pc + 32'd4));
      check($sformatf("%s s%0d inst", tag, s), 128'(pkt[s].inst),
            128'(TAG | pc));
    end else begin
      check($sformatf("%s s%0d zero", tag, s), 128'(pkt[s]), 0);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    @(negedge clock);
    reset = 1'b0;
    flush = 1'b0;
    mem_valid = v;
    dcnt = d;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    flush_pc = '0;
    mem_valid = 1'b1;
    dcnt = '0;

    // reset
    @(negedge clock); #1;
    check("rst req", 128'(req), 0);
    check("rst addr", 128'(addr), 0);
    chk_pkt("rst", 0, 1'b0, 0);
    chk_pkt("rst", 1, 1'b0, 0);
    @(negedge clock); #1;
    check("rst count", 128'(count), 0);

    // fill from 0 with no dispatch
    drive(1'b1, 2'd0);
    check("a0 req", 128'(req), 1);
    check("a0 addr", 128'(addr), 0);
    check("a0 count", 128'(count), 0);
    chk_pkt("a0", 0, BYP, 32'h0);
    chk_pkt("a0", 1, BYP, 32'h4);
    drive(1'b1, 2'd0);
    check("a1 addr", 128'(addr), 32'h8);
    check("a1 count", 128'(count), 2);
    chk_pkt("a1", 0, 1'b1, 32'h0);
    chk_pkt("a1", 1, 1'b1, 32'h4);
    drive(1'b1, 2'd0);
    check("a2 addr", 128'(addr), 32'h10);
    check("a2 count", 128'(count), 4);
    drive(1'b1, 2'd0);
    check("a3 addr", 128'(addr), 32'h18);
    check("a3 count", 128'(count), 6);
    check("a3 req", 128'(req), 1);

    // full, then flush to 0x104
    @(negedge clock);
    flush = 1'b1;
    flush_pc = 32'h104;
    #1;
    check("a4 count", 128'(count), 8);
    check("a4 req", 128'(req), 0);
    chk_pkt("a4 flush", 0, 1'b0, 0);
    chk_pkt("a4 flush", 1, 1'b0, 0);

    drive(1'b1, 2'd0);
    check("b1 count", 128'(count), 0);
    check("b1 addr", 128'(addr), 32'h100);
    check("b1 req", 128'(req), 1);
    chk_pkt("b1", 0, BYP, 32'h104);
    chk_pkt("b1", 1, 1'b0, 0);
    drive(1'b1, 2'd0);
    check("b2 count", 128'(count), 1);
    check("b2 addr", 128'(addr), 32'h108);
    chk_pkt("b2", 0, 1'b1, 32'h104);
    chk_pkt("b2", 1, 1'b0, 0);
    drive(1'b1, 2'd0);
    check("b3 count", 128'(count), 3);
    chk_pkt("b3", 1, 1'b1, 32'h108);
    drive(1'b1, 2'd0);
    check("b4 count", 128'(count), 5);

    // count 7: no request even while dispatching
    drive(1'b1, 2'd2);
    check("b5 count", 128'(count), 7);
    check("b5 req", 128'(req), 0);
    chk_pkt("b5", 0, 1'b1, 32'h104);
    chk_pkt("b5", 1, 1'b1, 32'h108);
    drive(1'b1, 2'd0);
    check("b6 count", 128'(count), 5);
    check("b6 req", 128'(req), 1);
    check("b6 addr", 128'(addr), 32'h120);
    chk_pkt("b6", 0, 1'b1, 32'h10C);
    drive(1'b1, 2'd2);
    check("b7 count", 128'(count), 7);
    check("b7 req", 128'(req), 0);
    chk_pkt("b7", 0, 1'b1, 32'h10C);
    chk_pkt("b7", 1, 1'b1, 32'h110);

    // steady state across the pointer wrap
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 2'd2);
      check($sformatf("ss%0d count", k), 128'(count), 5);
      check($sformatf("ss%0d req", k), 128'(req), 1);
      chk_pkt($sformatf("ss%0d", k), 0, 1'b1, 32'h114 + 32'(8 * k));
      chk_pkt($sformatf("ss%0d", k), 1, 1'b1, 32'h118 + 32'(8 * k));
    end

    // drain with memory idle
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 2'd1);
      check($sformatf("dr%0d count", k), 128'(count), 128'(5 - k));
      chk_pkt($sformatf("dr%0d", k), 0, 1'b1, 32'h144 + 32'(4 * k));
    end
    drive(1'b0, 2'd0);
    check("empty count", 128'(count), 0);
    check("empty addr", 128'(addr), 32'h158);
    check("empty req", 128'(req), 1);
    chk_pkt("empty", 0, 1'b0, 0);
    chk_pkt("empty", 1, 1'b0, 0);
    drive(1'b1, 2'd0);
    check("resume addr", 128'(addr), 32'h158);
    chk_pkt("resume", 0, BYP, 32'h158);
    chk_pkt("resume", 1, BYP, 32'h15C);
    drive(1'b0, 2'd1);
    check("resume count", 128'(count), 2);
    chk_pkt("resume1", 0, 1'b1, 32'h158);
    chk_pkt("resume1", 1, 1'b1, 32'h15C);

    // over-dispatch at count 1 is clamped
    drive(1'b0, 2'd2);
    check("ovr count", 128'(count), 1);
    chk_pkt("ovr", 0, 1'b1, 32'h15C);
    chk_pkt("ovr", 1, 1'b0, 0);
    drive(1'b1, 2'd0);
    check("clamp count", 128'(count), 0);
    check("clamp addr", 128'(addr), 32'h160);
    chk_pkt("clamp", 0, BYP, 32'h160);
    drive(1'b0, 2'd0);
    check("clamp2 count", 128'(count), 2);
    chk_pkt("clamp2", 0, 1'b1, 32'h160);
    chk_pkt("clamp2", 1, 1'b1, 32'h164);

    // reset mid-operation
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mrst req", 128'(req), 0);
    check("mrst addr", 128'(addr), 0);
    chk_pkt("mrst", 0, 1'b0, 0);
    drive(1'b0, 2'd0);
    check("mrst count", 128'(count), 0);
    check("mrst addr2", 128'(addr), 0);
    check("mrst req2", 128'(req), 1);

    // empty buffer, response at 0x20
    @(negedge clock);
    flush = 1'b1;
    flush_pc = 32'h20;
    mem_valid = 1'b0;
    #1;
    chk_pkt("fl20", 0, 1'b0, 0);
`ifdef FETCH_BUF_BYPASS_EN
    drive(1'b1, 2'd2);
    check("byp addr", 128'(addr), 32'h20);
    chk_pkt("byp", 0, 1'b1, 32'h20);
    chk_pkt("byp", 1, 1'b1, 32'h24);
    drive(1'b0, 2'd0);
    check("byp count", 128'(count), 0);
    chk_pkt("byp1", 0, 1'b0, 0);
`else
    drive(1'b1, 2'd0);
    check("nbyp addr", 128'(addr), 32'h20);
    chk_pkt("nbyp", 0, 1'b0, 0);
    drive(1'b0, 2'd0);
    check("nbyp count", 128'(count), 2);
    chk_pkt("nbyp1", 0, 1'b1, 32'h20);
    chk_pkt("nbyp1", 1, 1'b1, 32'h24);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
